ram_fifo_ctrl: RTL

// - Initiator for the dual-port byte RAM: drives its write port (add_w/data_w/w_en) and read port
//   (add_r/r_en, data_r returned) to turn the RAM into a valid/ready stream FIFO.
// - Sits between a producer and a consumer; RAM is instantiated beside it, not inside.
// - Full throughput: one push and one pop per cycle, despite the RAM's one-cycle read latency.

---
 rtl/ram_fifo_ctrl_pkg.sv | 13 +
 rtl/ram_fifo_outbuf.sv | 51 +++++
 rtl/ram_fifo_ctrl.sv | 91 +++++++++
 3 files changed

// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants for the RAM-backed stream FIFO controller and its output buffer.
package ram_fifo_ctrl_pkg;

    localparam int unsigned DEF_ADDR_SIZE = 10;
    localparam int unsigned DEF_WORD_SIZE = 8;
    localparam int unsigned DEPTH         = 1 << DEF_ADDR_SIZE;
    localparam int unsigned OUT_BUF       = 2;

    function automatic int unsigned depth_of(input int unsigned addr_size);
        return 1 << addr_size;
    endfunction

endpackage

// File: rtl/ram_fifo_outbuf.sv
// Two-entry registered output buffer that absorbs the RAM read latency.
module ram_fifo_outbuf
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned WordSize = DEF_WORD_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [WordSize-1:0] data_i,
    input  logic                pop_i,
    output logic [WordSize-1:0] data_o,
    output logic [1:0]          occ_o
);

    logic [WordSize-1:0] mem_q [OUT_BUF];
    logic                head_q, head_d;
    logic [1:0]          occ_q, occ_d;
    logic                wr_idx;

    always_comb begin
        // Upstream never pushes into a full buffer, so occ_q[0] picks the free slot.
        wr_idx = head_q ^ occ_q[0];
        head_d = head_q ^ pop_i;
        occ_d  = occ_q;
        if (push_i && !pop_i) begin
            occ_d = occ_q + 2'd1;
        end else if (!push_i && pop_i) begin
            occ_d = occ_q - 2'd1;
        end
        data_o = mem_q[head_q];
        occ_o  = occ_q;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            occ_q  <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Valid/ready stream FIFO built on an external dual-port RAM with one-cycle read latency.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int unsigned AddressSize = DEF_ADDR_SIZE,
    parameter int unsigned WordSize    = DEF_WORD_SIZE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WordSize-1:0]    in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WordSize-1:0]    out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AddressSize-1:0] add_w,
    output logic [WordSize-1:0]    data_w,
    output logic                   w_en,
    output logic [AddressSize-1:0] add_r,
    output logic                   r_en,
    input  logic [WordSize-1:0]    data_r,
    output logic [AddressSize:0]   count
);

    localparam logic [AddressSize:0]   DepthCnt = (AddressSize + 1)'(depth_of(AddressSize));
    localparam logic [AddressSize:0]   CntOne   = 1;
    localparam logic [AddressSize-1:0] PtrOne   = 1;

    logic [AddressSize-1:0] wr_ptr_q, wr_ptr_d;
    logic [AddressSize-1:0] rd_ptr_q, rd_ptr_d;
    logic [AddressSize:0]   ram_cnt_q, ram_cnt_d;
    logic                   inflight_q;
    logic [1:0]             occ;
    logic                   push, fetch, pop;
    logic [WordSize-1:0]    buf_data;

    always_comb begin
        in_ready  = rst_n & (ram_cnt_q != DepthCnt);
        push      = in_valid & in_ready;
        out_valid = rst_n & (occ != 2'd0);
        pop       = out_valid & out_ready;
        // Fetch only if the buffer still has room once the in-flight word lands.
        fetch     = rst_n & (ram_cnt_q != '0) &
                    (({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));

        wr_ptr_d  = push  ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d  = fetch ? rd_ptr_q + PtrOne : rd_ptr_q;
        ram_cnt_d = ram_cnt_q;
        if (push && !fetch) begin
            ram_cnt_d = ram_cnt_q + CntOne;
        end else if (!push && fetch) begin
            ram_cnt_d = ram_cnt_q - CntOne;
        end

        add_w    = wr_ptr_q;
        data_w   = in_data;
        w_en     = push;
        add_r    = rd_ptr_q;
        r_en     = fetch;
        out_data = buf_data;
        count    = rst_n ? ram_cnt_q + {{AddressSize{1'b0}}, inflight_q}
                           + {{(AddressSize - 1){1'b0}}, occ} : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            inflight_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_cnt_q  <= ram_cnt_d;
            inflight_q <= fetch;
        end
    end

    ram_fifo_outbuf #(
        .WordSize (WordSize)
    ) u_outbuf (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (inflight_q),
        .data_i (data_r),
        .pop_i  (pop),
        .data_o (buf_data),
        .occ_o  (occ)
    );

endmodule
